gpio_host_sequencer: RTL
========================

# gpio_host_sequencer

- Hardware stand-in for the soft processor on the host side of the 32-bit GPIO link into the convolution datapath.
- Accepts commands over a valid/ready port and drives the device-bound GPIO word with the correct ctrl/valid strobing; the sequenced commands are kernel load, image size, image load, data request and run.
- Captures device readback words and waits for end-of-process.
- Lets benches and on-chip self-test exercise the control block without a CPU.

## Interface
- `GPIO_D`, 32: GPIO word width.
- `DATA_LEN`, 24: payload width carried in GPIO bits [24:1].
- `HOLD_CYCLES`, 4: cycles the valid bit is held high per command (≥1).
- `GAP_CYCLES`, 4: cycles valid is held low after each strobe (≥1).
- `RESP_LAT`, 8: cycles from end of gap to readback capture (≥1).
- `RST_CYCLES`, 16: cycles device reset bit is held after local reset release (≥1).
- `TIMEOUT`, 65535: maximum cycles waited for end-of-process.
- `i_CLK`  in  1  system clock.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_cmd`  in  3  ctrl code: 0 kernel load, 1 image size, 2 image load, 3 data request, 4 load finish/run.
- `i_cmd_data`  in  DATA_LEN  payload.
- `i_cmd_valid`  in  1  command present.
- `o_cmd_ready`  out  1  sequencer idle, command accepted when valid&ready.
- `o_gpio`  out  GPIO_D  to device GPIO input: bit0 device reset, [24:1] data, [27:25] sequence field, [28] valid, [31:29] ctrl.
- `i_gpio`  in  GPIO_D  device readback word.
- `i_eop`  in  1  device end-of-process.
- `o_resp_data`  out  GPIO_D  captured readback.
- `o_resp_valid`  out  1  one-cycle pulse with new o_resp_data.
- `o_done`  out  1  one-cycle pulse: run completed with i_eop.
- `o_timeout`  out  1  one-cycle pulse: run abandoned.
- `o_err`  out  1  one-cycle pulse: illegal ctrl code (5–7) accepted and dropped.

## Operation
- FSM states are DEVRST, IDLE, SETUP, STROBE, GAP, WAIT_RESP and WAIT_EOP.
- DEVRST:
  - Entered on i_rst.
  - o_gpio = 32'h1 and ready = 0.
  - After i_rst falls, RST_CYCLES cycles are counted, then o_gpio = 0 and the state goes to IDLE.
- IDLE:
  - ready = 1.
  - Legal command: latch i_cmd and i_cmd_data, go to SETUP.
  - Code 5–7: pulse o_err next cycle, stay IDLE, o_gpio unchanged.
- SETUP (1 cycle): ctrl and data driven, valid = 0.
- STROBE: valid = 1 for HOLD_CYCLES cycles, with ctrl and data held.
- GAP:
  - valid = 0 for GAP_CYCLES cycles, with ctrl and data held.
  - Next state: code 3 → WAIT_RESP; code 4 → WAIT_EOP; else IDLE.
- WAIT_RESP:
  - Count RESP_LAT cycles, then register i_gpio into o_resp_data with o_resp_valid pulsed.
  - Go to IDLE.
- WAIT_EOP:
  - Sample i_eop each cycle. When high → o_done pulse, go to IDLE.
  - After TIMEOUT cycles without i_eop → o_timeout pulse, go to IDLE.
  - If i_eop is high on entry, done follows in the first WAIT_EOP cycle.
- i_eop is ignored outside WAIT_EOP.
- i_gpio is sampled only at the WAIT_RESP capture.
- o_gpio[31:29] and [24:1] retain the last command after returning to IDLE; bit0 and bit28 are 0.
- Payload is zero-extended if DATA_LEN < 24.
- i_rst mid-command aborts immediately to DEVRST:
  - Pending pulses are suppressed.
  - o_resp_data is cleared.
  - A full device-reset sequence follows.

## Timing
- All outputs registered.
- Reset values:
  - o_gpio = 32'h1.
  - o_cmd_ready = 0.
  - o_resp_data = 0.
  - o_resp_valid, o_done, o_timeout and o_err = 0.
- Accept at cycle 0.
  - Cycle 1: ctrl/data visible, valid 0.
  - Cycles 2..HOLD_CYCLES+1: valid 1.
  - Then GAP_CYCLES cycles of valid 0.
- Plain commands: ready reasserts at cycle 2+HOLD_CYCLES+GAP_CYCLES.
- Data request: o_resp_valid at cycle 2+HOLD_CYCLES+GAP_CYCLES+RESP_LAT, with ready on the following cycle.
- ready is deasserted the cycle after acceptance; back-to-back commands are never accepted.
- o_err pulse occurs one cycle after the illegal accept; ready remains 1.

## Configuration
- `GPIO_HOST_SEQ_EN`:
  - Defined: o_gpio[27:25] carries a 3-bit counter.
    - Reset to 0.
    - Incremented, mod 8, at each SETUP entry.
    - Value shown during SETUP/STROBE/GAP is the pre-increment count of that command.
  - Undefined: bits [27:25] are constant 0 and the counter is not built.

## Test plan
- Reset: release i_rst with RST_CYCLES=16 → o_gpio=32'h1 for 16 cycles, then 0, then ready=1.
- Kernel load: cmd 0, data 24'h0102FF → o_gpio = {3'd0,1'b1,3'bx,24'h0102FF,1'b0} for exactly 4 cycles; ready returns 10 cycles after accept.
- Data request: cmd 3, i_gpio = 32'hDEAD0123 → o_resp_valid pulse at accept+18 with o_resp_data = 32'hDEAD0123.
- Run completion and timeout:
  - Run with i_eop: cmd 4, i_eop rises 50 cycles into WAIT_EOP → single o_done pulse, no o_timeout.
  - Run with TIMEOUT=100 and i_eop held 0 → o_timeout pulse; ready back.
- Illegal code and abort:
  - cmd 6 → o_err pulse, o_gpio unchanged, ready stays 1.
  - Assert i_rst during STROBE → o_gpio=32'h1 next cycle, no pulses, full DEVRST sequence.
- With `GPIO_HOST_SEQ_EN`: 9 consecutive commands → bits [27:25] read 0..7 then 0.

Source files
------------

// File: rtl/gpio_host_sequencer.sv
// Host-side GPIO link sequencer: strobes commands onto the device GPIO word and collects readback/end-of-process.
// Optional macro GPIO_HOST_SEQ_EN adds a 3-bit command sequence counter on o_gpio[27:25].
module gpio_host_sequencer #(
    parameter int GPIO_D      = 32,
    parameter int DATA_LEN    = 24,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 4,
    parameter int RESP_LAT    = 8,
    parameter int RST_CYCLES  = 16,
    parameter int TIMEOUT     = 65535
) (
    input  logic                i_CLK,
    input  logic                i_rst,
    input  logic [2:0]          i_cmd,
    input  logic [DATA_LEN-1:0] i_cmd_data,
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    output logic [GPIO_D-1:0]   o_gpio,
    input  logic [GPIO_D-1:0]   i_gpio,
    input  logic                i_eop,
    output logic [GPIO_D-1:0]   o_resp_data,
    output logic                o_resp_valid,
    output logic                o_done,
    output logic                o_timeout,
    output logic                o_err
);

    localparam logic [2:0] S_DEVRST    = 3'd0;
    localparam logic [2:0] S_IDLE      = 3'd1;
    localparam logic [2:0] S_SETUP     = 3'd2;
    localparam logic [2:0] S_STROBE    = 3'd3;
    localparam logic [2:0] S_GAP       = 3'd4;
    localparam logic [2:0] S_WAIT_RESP = 3'd5;
    localparam logic [2:0] S_WAIT_EOP  = 3'd6;

    localparam logic [2:0] CMD_DATA_REQ = 3'd3;
    localparam logic [2:0] CMD_RUN      = 3'd4;

    localparam int VALID_BIT = 28;

    logic [2:0]        state_q, state_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [2:0]        cmd_q, cmd_d;
    logic [GPIO_D-1:0] gpio_q, gpio_d;
    logic              ready_q, ready_d;
    logic [GPIO_D-1:0] resp_data_q, resp_data_d;
    logic              resp_valid_q, resp_valid_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic              err_q, err_d;

    logic              accept;
    logic              legal_cmd;
    logic [2:0]        seq_field;
    logic [23:0]       payload;
    logic [31:0]       cmd_word;

    assign accept    = (state_q == S_IDLE) && ready_q && i_cmd_valid;
    assign legal_cmd = (i_cmd <= CMD_RUN);
    assign payload   = 24'(i_cmd_data);
    assign cmd_word  = {i_cmd, 1'b0, seq_field, payload, 1'b0};

`ifdef GPIO_HOST_SEQ_EN
    logic [2:0] seq_q, seq_d;

    // Count advances on the accept edge, so the word latched for SETUP carries the pre-increment value.
    always_comb begin
        seq_d = seq_q;
        if (accept && legal_cmd) begin
            seq_d = seq_q + 3'd1;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_rst) begin
            seq_q <= '0;
        end else begin
            seq_q <= seq_d;
        end
    end

    assign seq_field = seq_q;
`else
    assign seq_field = '0;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cmd_d        = cmd_q;
        gpio_d       = gpio_q;
        ready_d      = ready_q;
        resp_data_d  = resp_data_q;
        resp_valid_d = 1'b0;
        done_d       = 1'b0;
        timeout_d    = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            S_DEVRST: begin
                gpio_d    = '0;
                gpio_d[0] = 1'b1;
                ready_d   = 1'b0;
                if (cnt_q == 32'(RST_CYCLES - 1)) begin
                    gpio_d  = '0;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            S_IDLE: begin
                ready_d = 1'b1;
                if (accept) begin
                    if (legal_cmd) begin
                        cmd_d   = i_cmd;
                        gpio_d  = GPIO_D'(cmd_word);
                        ready_d = 1'b0;
                        state_d = S_SETUP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_SETUP: begin
                gpio_d[VALID_BIT] = 1'b1;
                cnt_d             = '0;
                state_d           = S_STROBE;
            end

            S_STROBE: begin
                if (cnt_q == 32'(HOLD_CYCLES - 1)) begin
                    gpio_d[VALID_BIT] = 1'b0;
                    cnt_d             = '0;
                    state_d           = S_GAP;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            S_GAP: begin
                if (cnt_q == 32'(GAP_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (cmd_q == CMD_DATA_REQ) begin
                        state_d = S_WAIT_RESP;
                    end else if (cmd_q == CMD_RUN) begin
                        state_d = S_WAIT_EOP;
                    end else begin
                        ready_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            // Ready stays low here; IDLE raises it one cycle after the capture pulse.
            S_WAIT_RESP: begin
                if (cnt_q == 32'(RESP_LAT - 1)) begin
                    resp_data_d  = i_gpio;
                    resp_valid_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            S_WAIT_EOP: begin
                if (i_eop) begin
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == 32'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    ready_d   = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            default: begin
                ready_d = 1'b0;
                cnt_d   = '0;
                state_d = S_DEVRST;
            end
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_rst) begin
            state_q      <= S_DEVRST;
            cnt_q        <= '0;
            cmd_q        <= '0;
            gpio_q       <= GPIO_D'(1);
            ready_q      <= 1'b0;
            resp_data_q  <= '0;
            resp_valid_q <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cmd_q        <= cmd_d;
            gpio_q       <= gpio_d;
            ready_q      <= ready_d;
            resp_data_q  <= resp_data_d;
            resp_valid_q <= resp_valid_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            err_q        <= err_d;
        end
    end

    assign o_cmd_ready  = ready_q;
    assign o_gpio       = gpio_q;
    assign o_resp_data  = resp_data_q;
    assign o_resp_valid = resp_valid_q;
    assign o_done       = done_q;
    assign o_timeout    = timeout_q;
    assign o_err        = err_q;

endmodule
